// File: rtl/rs422_test_ctrl_if.sv
// rs422_test_ctrl_if: control, checker handshake and statistics bundle for the rs422 test sequencer.
interface rs422_test_ctrl_if;
  logic        test_en;
  logic        test_abort;
  logic        RS422_START;
  logic        RS422_FINISH;
  logic [31:0] RS422_ERROR;
  logic        test_busy;
  logic        test_done;
  logic        test_pass;
  logic        timeout_flag;
  logic [15:0] run_cnt;
  logic [31:0] err_last;
  logic [31:0] err_max;
  logic [39:0] err_total;
  modport master (
    input  test_en, test_abort, RS422_FINISH, RS422_ERROR,
    output RS422_START, test_busy, test_done, test_pass, timeout_flag,
           run_cnt, err_last, err_max, err_total
  );
  modport slave (
    output test_en, test_abort, RS422_FINISH, RS422_ERROR,
    input  RS422_START, test_busy, test_done, test_pass, timeout_flag,
           run_cnt, err_last, err_max, err_total
  );
endinterface

// File: rtl/rs422_test_ctrl.sv
// rs422_test_ctrl: runs the rs422 loopback BER checker RUN_NUM times, gathers error statistics
// and reports a pass/fail verdict against ERR_THRESH.
module rs422_test_ctrl #(
  parameter int RUN_NUM     = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int GAP_CYC     = 16,
  parameter int ERR_THRESH  = 0
) (
  input logic sys_clk,
  input logic sys_rst,
  rs422_test_ctrl_if.master io
);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    GAP   = 5'b00010,
    START = 5'b00100,
    WAIT  = 5'b01000,
    DONE  = 5'b10000
  } state_t;
  state_t st;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic finish_d, aborted, fin_edge, gap_ok, to_hit, last_run, abort_now;
  logic [40:0] sum;
  always_comb begin
    fin_edge  = io.RS422_FINISH && !finish_d;
    gap_ok    = gap_cnt >= GW'(GAP_CYC - 1);
    to_hit    = to_cnt == TW'(TIMEOUT_CYC - 1);
    last_run  = (io.run_cnt + 16'd1) == 16'(RUN_NUM);
    abort_now = io.test_abort && (st == GAP || st == START || st == WAIT);
    sum       = {1'b0, io.err_total} + {9'd0, io.RS422_ERROR};
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st              <= IDLE;
      gap_cnt         <= '0;
      to_cnt          <= '0;
      finish_d        <= 1'b0;
      aborted         <= 1'b0;
      io.RS422_START  <= 1'b0;
      io.test_busy    <= 1'b0;
      io.test_done    <= 1'b0;
      io.test_pass    <= 1'b0;
      io.timeout_flag <= 1'b0;
      io.run_cnt      <= '0;
      io.err_last     <= '0;
      io.err_max      <= '0;
      io.err_total    <= '0;
    end else begin
      finish_d       <= io.RS422_FINISH;
      io.RS422_START <= 1'b0;
      io.test_done   <= 1'b0;
      if (abort_now) begin
        st           <= DONE;
        aborted      <= 1'b1;
        io.test_done <= 1'b1;
      end else begin
        case (st)
          IDLE: if (io.test_en) begin
            st              <= GAP;
            io.test_busy    <= 1'b1;
            io.run_cnt      <= '0;
            io.err_last     <= '0;
            io.err_max      <= '0;
            io.err_total    <= '0;
            io.test_pass    <= 1'b0;
            io.timeout_flag <= 1'b0;
            aborted         <= 1'b0;
            finish_d        <= 1'b0;
            gap_cnt         <= '0;
          end
          // the checker restarts on any START seen while idle, so wait for FINISH to drop
          GAP: if (gap_ok && !io.RS422_FINISH) begin
            st             <= START;
            io.RS422_START <= 1'b1;
          end else if (!gap_ok) gap_cnt <= gap_cnt + 1'b1;
          START: begin
            to_cnt <= '0;
            st     <= WAIT;
          end
          WAIT: begin
            to_cnt <= to_cnt + 1'b1;
            if (fin_edge) begin
              io.err_last  <= io.RS422_ERROR;
              io.err_max   <= io.RS422_ERROR > io.err_max ? io.RS422_ERROR : io.err_max;
              io.err_total <= sum[40] ? '1 : sum[39:0];
              io.run_cnt   <= io.run_cnt + 16'd1;
              st           <= last_run ? DONE : GAP;
              io.test_done <= last_run;
              gap_cnt      <= '0;
            end else if (to_hit) begin
              io.timeout_flag <= 1'b1;
              io.test_done    <= 1'b1;
              st              <= DONE;
            end
          end
          DONE: begin
            io.test_pass <= !io.timeout_flag && !aborted && (io.err_total <= 40'(ERR_THRESH));
            io.test_busy <= 1'b0;
            st           <= IDLE;
          end
          default: begin
            io.test_busy <= 1'b0;
            st           <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rs422_test_ctrl.sv
// tb_rs422_test_ctrl: randomized sequencer bench; the bench plays the BER checker and predicts
// statistics from the list of per-run error counts it hands out.
module tb_rs422_test_ctrl;
  localparam int GAP = 4;
  localparam int TO  = 200;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic test_en = 1'b0, test_abort = 1'b0, finish = 1'b0;
  logic [31:0] error = '0;
  bit sel_c = 1'b0;
  int checks = 0, errors = 0, cyc = 0, done_seen = 0;
  logic [31:0] errs [300];
  logic [31:0] exp_last, exp_max;
  logic [39:0] exp_total;
  logic start_s, done_s, busy_s;
  logic [15:0] run_s;
  rs422_test_ctrl_if ia(), ib(), ic();
  assign ia.test_en = test_en;  assign ib.test_en = test_en;  assign ic.test_en = test_en;
  assign ia.test_abort = test_abort;  assign ib.test_abort = test_abort;  assign ic.test_abort = test_abort;
  assign ia.RS422_FINISH = finish;  assign ib.RS422_FINISH = finish;  assign ic.RS422_FINISH = finish;
  assign ia.RS422_ERROR = error;  assign ib.RS422_ERROR = error;  assign ic.RS422_ERROR = error;
  assign start_s = sel_c ? ic.RS422_START : ia.RS422_START;
  assign done_s  = sel_c ? ic.test_done : ia.test_done;
  assign busy_s  = sel_c ? ic.test_busy : ia.test_busy;
  assign run_s   = sel_c ? ic.run_cnt : ia.run_cnt;
  rs422_test_ctrl #(.RUN_NUM(3), .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .ERR_THRESH(15))
    dut_a (.sys_clk(sys_clk), .sys_rst(sys_rst), .io(ia));
  rs422_test_ctrl #(.RUN_NUM(3), .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .ERR_THRESH(16))
    dut_b (.sys_clk(sys_clk), .sys_rst(sys_rst), .io(ib));
  rs422_test_ctrl #(.RUN_NUM(300), .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .ERR_THRESH(0))
    dut_c (.sys_clk(sys_clk), .sys_rst(sys_rst), .io(ic));
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (done_s) done_seen <= done_seen + 1;
  end
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask
  function automatic void model(input int n);
    longint t = 0;
    exp_last = '0;
    exp_max  = '0;
    for (int i = 0; i < n; i++) begin
      t += longint'(errs[i]);
      exp_last = errs[i];
      if (errs[i] > exp_max) exp_max = errs[i];
    end
    exp_total = (t > 64'hFF_FFFF_FFFF) ? 40'hFF_FFFF_FFFF : t[39:0];
  endfunction
  // Acts as the checker: answers each START with a FINISH level held for `hold` cycles.
  task automatic run_seq(input int nruns, input int hold, input int abort_run, input bit poke_en);
    int w, prev, base_done, exp_cnt;
    bit last;
    base_done = done_seen;
    prev = 0;
    test_en = 1'b1;
    tick;
    test_en = 1'b0;
    checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL busy_after_en got %b exp 1", busy_s); end
    for (int r = 0; r < nruns; r++) begin
      w = 0;
      while (!start_s && w < 1000) begin tick; w++; end
      checks++;
      if (!start_s) begin errors++; $display("FAIL start_wait run %0d got no START exp START", r); return; end
      if (r == 0) begin
        checks++;
        if (w < GAP || w > GAP + 2) begin errors++; $display("FAIL start_latency got %0d exp %0d..%0d", w, GAP, GAP + 2); end
      end else begin
        checks++;
        if (cyc - prev <= GAP) begin errors++; $display("FAIL start_spacing run %0d got %0d exp >%0d", r, cyc - prev, GAP); end
      end
      prev = cyc;
      tick;
      checks++; if (start_s !== 1'b0) begin errors++; $display("FAIL start_width run %0d got %b exp 0", r, start_s); end
      repeat ($urandom_range(0, 4)) tick;
      finish = 1'b1;
      error = errs[r];
      if (r == abort_run) test_abort = 1'b1;
      tick;
      test_abort = 1'b0;
      exp_cnt = (r == abort_run) ? r : r + 1;
      last = (r == abort_run) || (r == nruns - 1);
      checks++; if (run_s !== 16'(exp_cnt)) begin errors++; $display("FAIL run_cnt_edge run %0d got %0d exp %0d", r, run_s, exp_cnt); end
      checks++; if (done_s !== last) begin errors++; $display("FAIL done_timing run %0d got %b exp %b", r, done_s, last); end
      for (int h = 1; h < hold; h++) begin
        if (poke_en && h == 1) test_en = 1'b1;
        tick;
        test_en = 1'b0;
        checks++;
        if (start_s !== 1'b0 || run_s !== 16'(exp_cnt)) begin
          errors++; $display("FAIL hold_latch run %0d got start=%b cnt=%0d exp start=0 cnt=%0d", r, start_s, run_s, exp_cnt);
        end
      end
      finish = 1'b0;
      error = $urandom;
      if (last) break;
    end
    tick;
    checks++; if (done_seen - base_done != 1) begin errors++; $display("FAIL done_pulses got %0d exp 1", done_seen - base_done); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL busy_end got %b exp 0", busy_s); end
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if ({ia.RS422_START, ia.test_busy, ia.test_done, ia.test_pass, ia.timeout_flag, ia.run_cnt, ia.err_last, ia.err_max, ia.err_total} !== '0) begin
      errors++; $display("FAIL reset_a got nonzero outputs exp all 0");
    end
    checks++;
    if ({ic.RS422_START, ic.test_busy, ic.test_done, ic.test_pass, ic.timeout_flag, ic.run_cnt, ic.err_last, ic.err_max, ic.err_total} !== '0) begin
      errors++; $display("FAIL reset_c got nonzero outputs exp all 0");
    end
    tick;
    sys_rst = 1'b0;
    tick;
  endtask
  task automatic test_stats;
    int hold;
    bit poke;
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 3; i++) errs[i] = 32'($urandom_range(0, 10));
      if (k == 0) begin errs[0] = 0; errs[1] = 0; errs[2] = 0; end
      if (k == 1) begin errs[0] = 5; errs[1] = 2; errs[2] = 9; end
      hold = (k == 2) ? 3 : (k < 2 ? 1 : $urandom_range(1, 4));
      poke = (k == 2) ? 1'b1 : 1'(k > 2 && $urandom_range(0, 1) == 1);
      run_seq(3, hold, -1, poke);
      model(3);
      checks++; if (ia.run_cnt !== 16'd3) begin errors++; $display("FAIL run_cnt case %0d got %0d exp 3", k, ia.run_cnt); end
      checks++; if (ia.err_last !== exp_last) begin errors++; $display("FAIL err_last case %0d got %0d exp %0d", k, ia.err_last, exp_last); end
      checks++; if (ia.err_max !== exp_max) begin errors++; $display("FAIL err_max case %0d got %0d exp %0d", k, ia.err_max, exp_max); end
      checks++; if (ia.err_total !== exp_total) begin errors++; $display("FAIL err_total case %0d got %0d exp %0d", k, ia.err_total, exp_total); end
      checks++; if (ia.test_pass !== (exp_total <= 15)) begin errors++; $display("FAIL pass_t15 case %0d got %b exp %b", k, ia.test_pass, exp_total <= 15); end
      checks++; if (ib.test_pass !== (exp_total <= 16)) begin errors++; $display("FAIL pass_t16 case %0d got %b exp %b", k, ib.test_pass, exp_total <= 16); end
      checks++; if (ia.timeout_flag !== 1'b0) begin errors++; $display("FAIL timeout_stats case %0d got %b exp 0", k, ia.timeout_flag); end
      repeat ($urandom_range(1, 5)) tick;
    end
  endtask
  task automatic test_abort_run;
    for (int i = 0; i < 3; i++) errs[i] = 32'($urandom_range(0, 5));
    run_seq(3, 1, 1, 1'b0);
    model(1);
    checks++; if (ia.run_cnt !== 16'd1) begin errors++; $display("FAIL abort_cnt got %0d exp 1", ia.run_cnt); end
    checks++; if (ia.err_total !== exp_total) begin errors++; $display("FAIL abort_total got %0d exp %0d", ia.err_total, exp_total); end
    checks++; if (ia.test_pass !== 1'b0 || ib.test_pass !== 1'b0) begin errors++; $display("FAIL abort_pass got %b%b exp 00", ia.test_pass, ib.test_pass); end
    tick;
  endtask
  task automatic test_timeout;
    int w;
    test_en = 1'b1;
    tick;
    test_en = 1'b0;
    w = 0;
    while (!ia.RS422_START && w < 50) begin tick; w++; end
    checks++; if (!ia.RS422_START) begin errors++; $display("FAIL to_start got no START exp START"); end
    repeat (TO) tick;
    checks++; if (ia.timeout_flag !== 1'b0 || ia.test_done !== 1'b0) begin errors++; $display("FAIL to_early got flag=%b done=%b exp 00", ia.timeout_flag, ia.test_done); end
    tick;
    checks++; if (ia.timeout_flag !== 1'b1 || ia.test_done !== 1'b1) begin errors++; $display("FAIL to_flag got flag=%b done=%b exp 11", ia.timeout_flag, ia.test_done); end
    tick;
    checks++;
    if (ia.test_pass !== 1'b0 || ib.test_pass !== 1'b0 || ia.run_cnt !== 16'd0 || ia.test_busy !== 1'b0 || ia.test_done !== 1'b0) begin
      errors++; $display("FAIL to_end got pass=%b cnt=%0d busy=%b exp pass=0 cnt=0 busy=0", ia.test_pass, ia.run_cnt, ia.test_busy);
    end
  endtask
  task automatic test_reset_mid_wait;
    int w;
    bit seen;
    test_en = 1'b1;
    tick;
    test_en = 1'b0;
    w = 0;
    while (!ia.RS422_START && w < 50) begin tick; w++; end
    repeat (3) tick;
    checks++; if (ia.test_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp 1", ia.test_busy); end
    sys_rst = 1'b1;
    #2;
    checks++;
    if ({ia.RS422_START, ia.test_busy, ia.test_done, ia.test_pass, ia.timeout_flag, ia.run_cnt, ia.err_last, ia.err_max, ia.err_total} !== '0) begin
      errors++; $display("FAIL midrst_outputs got nonzero outputs exp all 0");
    end
    sys_rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin tick; if (ia.RS422_START || ia.test_busy) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL midrst_idle got activity exp idle"); end
  endtask
  task automatic test_saturation;
    sel_c = 1'b1;
    for (int i = 0; i < 300; i++) errs[i] = 32'hFFFF_FFFF;
    run_seq(300, 1, -1, 1'b0);
    model(300);
    checks++; if (ic.run_cnt !== 16'd300) begin errors++; $display("FAIL sat_cnt got %0d exp 300", ic.run_cnt); end
    checks++; if (ic.err_total !== exp_total) begin errors++; $display("FAIL sat_total got %h exp %h", ic.err_total, exp_total); end
    checks++; if (ic.err_max !== exp_max || ic.err_last !== exp_last) begin errors++; $display("FAIL sat_max got %h/%h exp %h/%h", ic.err_max, ic.err_last, exp_max, exp_last); end
    checks++; if (ic.test_pass !== 1'b0) begin errors++; $display("FAIL sat_pass got %b exp 0", ic.test_pass); end
    sel_c = 1'b0;
  endtask
  initial begin
    test_reset;
    test_stats;
    test_abort_run;
    test_timeout;
    test_reset_mid_wait;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
